sliding_window_3x3: RTL

SLIDING_WINDOW_3X3 -- requirements
Module: sliding_window_3x3

---
 rtl/sliding_window_3x3_pkg.sv | 22 ++
 rtl/sliding_window_3x3_if.sv | 30 +++
 rtl/sliding_window_3x3_line_buffer.sv | 43 ++++
 rtl/sliding_window_3x3.sv | 110 +++++++++++
 4 files changed

// File: rtl/sliding_window_3x3_pkg.sv
// Shared image-processing constants: default pixel width, 3x3 window size
// and row-major window index names, plus a (row,col) -> window index helper.
package image_proc_pkg;

   localparam int DATA_WIDTH_DEFAULT = 8;
   localparam int WINDOW_SIZE        = 9;

   localparam int WIN_TL     = 0;
   localparam int WIN_TC     = 1;
   localparam int WIN_TR     = 2;
   localparam int WIN_ML     = 3;
   localparam int WIN_CENTER = 4;
   localparam int WIN_MR     = 5;
   localparam int WIN_BL     = 6;
   localparam int WIN_BC     = 7;
   localparam int WIN_BR     = 8;

   function automatic int win_idx(input int row, input int col);
      return row * 3 + col;
   endfunction

endpackage

// File: rtl/sliding_window_3x3_if.sv
// Pixel-in / window-out bundle for sliding_window_3x3.
// frame_done exists only when WINDOW_FRAME_DONE_EN is defined.
interface sliding_window_3x3_if #(
   parameter int DATA_WIDTH  = image_proc_pkg::DATA_WIDTH_DEFAULT,
   parameter int WINDOW_SIZE = image_proc_pkg::WINDOW_SIZE
) ();

   // pixel_valid qualifies pixel_in and sof on every rising edge; there is no
   // ready, so every valid pixel is taken and every window_valid pulse must be
   // consumed in the cycle it appears.
   logic [DATA_WIDTH-1:0] pixel_in;
   logic                  pixel_valid;
   logic                  sof;
   logic [DATA_WIDTH-1:0] window [0:WINDOW_SIZE-1];
   logic                  window_valid;
`ifdef WINDOW_FRAME_DONE_EN
   logic                  frame_done;

   modport master (output pixel_in, pixel_valid, sof,
                   input  window, window_valid, frame_done);
   modport slave  (input  pixel_in, pixel_valid, sof,
                   output window, window_valid, frame_done);
`else
   modport master (output pixel_in, pixel_valid, sof,
                   input  window, window_valid);
   modport slave  (input  pixel_in, pixel_valid, sof,
                   output window, window_valid);
`endif

endinterface

// File: rtl/sliding_window_3x3_line_buffer.sv
// IMG_WIDTH-deep delay line with enable: data_o is the sample written
// IMG_WIDTH enabled cycles ago. Storage is deliberately not reset.
module line_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   localparam int PTR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

   logic [DATA_WIDTH-1:0] mem_q [0:IMG_WIDTH-1];
   logic [PTR_W-1:0]      ptr_q, ptr_d;

   // Read-before-write at the same slot yields exactly one line of delay.
   assign data_o = mem_q[ptr_q];

   always_comb begin
      ptr_d = ptr_q;
      if (en_i) begin
         ptr_d = (ptr_q == PTR_W'(IMG_WIDTH - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (en_i) begin
         mem_q[ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/sliding_window_3x3.sv
// Raster-scan 3x3 neighbourhood generator with two line buffers.
// Define WINDOW_FRAME_DONE_EN to add the frame_done end-of-frame pulse.
module sliding_window_3x3 #(
   parameter int DATA_WIDTH  = image_proc_pkg::DATA_WIDTH_DEFAULT,
   parameter int IMG_WIDTH   = 640,
   parameter int IMG_HEIGHT  = 480,
   parameter int WINDOW_SIZE = image_proc_pkg::WINDOW_SIZE
) (
   input  logic                 clk,
   input  logic                 rst,
   sliding_window_3x3_if.slave  bus
);

   import image_proc_pkg::*;

   localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   logic                  accept;
   logic [COL_W-1:0]      col_q, col_d, col_cur;
   logic [ROW_W-1:0]      row_q, row_d, row_cur;
   logic                  last_col, last_row;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] lb1_out, lb2_out;
   logic [DATA_WIDTH-1:0] win_q [0:WINDOW_SIZE-1];
   logic [DATA_WIDTH-1:0] win_d [0:WINDOW_SIZE-1];

   assign accept = bus.pixel_valid;

   line_buffer #(.DATA_WIDTH(DATA_WIDTH), .IMG_WIDTH(IMG_WIDTH)) u_lb1 (
      .clk(clk), .rst(rst), .en_i(accept), .data_i(bus.pixel_in), .data_o(lb1_out)
   );

   line_buffer #(.DATA_WIDTH(DATA_WIDTH), .IMG_WIDTH(IMG_WIDTH)) u_lb2 (
      .clk(clk), .rst(rst), .en_i(accept), .data_i(lb1_out), .data_o(lb2_out)
   );

   // sof forces the accepted pixel to (0,0); the row>=2 gate then keeps any
   // stale line-buffer contents out of the next valid window.
   always_comb begin
      col_cur  = bus.sof ? '0 : col_q;
      row_cur  = bus.sof ? '0 : row_q;
      last_col = (col_cur == COL_W'(IMG_WIDTH - 1));
      last_row = (row_cur == ROW_W'(IMG_HEIGHT - 1));
      col_d    = col_q;
      row_d    = row_q;
      valid_d  = 1'b0;
      if (accept) begin
         col_d   = last_col ? '0 : col_cur + COL_W'(1);
         row_d   = last_col ? (last_row ? '0 : row_cur + ROW_W'(1)) : row_cur;
         valid_d = (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));
      end
   end

   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_d[win_idx(r, 0)] = win_q[win_idx(r, 1)];
            win_d[win_idx(r, 1)] = win_q[win_idx(r, 2)];
         end
         win_d[WIN_TR] = lb2_out;
         win_d[WIN_MR] = lb1_out;
         win_d[WIN_BR] = bus.pixel_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < WINDOW_SIZE; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         for (int i = 0; i < WINDOW_SIZE; i++) begin
            win_q[i] <= win_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < WINDOW_SIZE; i++) begin
         bus.window[i] = win_q[i];
      end
   end

   assign bus.window_valid = valid_q;

`ifdef WINDOW_FRAME_DONE_EN
   logic done_q, done_d;

   assign done_d = accept && last_row && last_col;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

   assign bus.frame_done = done_q;
`endif

endmodule
